cache_req_ctrl: RTL and testbench
=================================

Name: cache_req_ctrl

Overview:
- Request sequencer between the CPU load/store port and the 4-way LRU cache_memory_lru block, plus a backing-memory port.
- Accepts one CPU request at a time over a valid/ready handshake and drives the cache lookup/write strobes.
- On a read miss, fetches the word from memory and fills the cache with it. Writes are write-through.
- Keeps hit and miss statistics and aborts memory transactions that exceed a timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 256, memory cycles allowed before abort (min 2)
CNT_W, 16, width of the hit and miss statistics counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cpu_req_valid  in  1  CPU request valid
cpu_req_ready  out  1  controller can accept a request
cpu_req_we  in  1  1 = write, 0 = read
cpu_req_addr  in  ADDR_W  request address
cpu_req_wdata  in  DATA_W  write data
cpu_rsp_valid  out  1  one-cycle response strobe
cpu_rsp_data  out  DATA_W  read data (0 for writes and errors)
cpu_rsp_err  out  1  timeout error flag, qualified by cpu_rsp_valid
cache_addr  out  ADDR_W  cache address
cache_data_in  out  DATA_W  cache write data
cache_we  out  1  cache write/allocate strobe
cache_re  out  1  cache lookup strobe
cache_data_out  in  DATA_W  cache read data (registered, 1-cycle latency)
cache_hit  in  1  cache hit (registered, 1-cycle latency)
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory request accepted
mem_req_we  out  1  memory write
mem_req_addr  out  ADDR_W  memory address
mem_req_wdata  out  DATA_W  memory write data
mem_rsp_valid  in  1  memory read data valid
mem_rsp_data  in  DATA_W  memory read data
busy  out  1  FSM not in IDLE
hit_cnt  out  CNT_W  saturating read-hit count
miss_cnt  out  CNT_W  saturating read-miss count

Behaviour:
- Reset (async, active-high): FSM goes to IDLE. All outputs are 0, except cpu_req_ready = 1. Counters clear.
- Reset mid-transaction abandons the transaction. No response is issued and no fill occurs.
- Captured registers: addr, we and wdata are latched on cpu_req_valid && cpu_req_ready.
  - cache_addr and mem_req_addr drive the captured address in all non-IDLE states, and 0 in IDLE.
- State IDLE:
  - cpu_req_ready = 1.
  - On handshake, go to LOOKUP for a read, or WR_CACHE for a write.
- State LOOKUP: cache_re = 1 for exactly one cycle, then go to CHECK.
- State CHECK: sample cache_hit and cache_data_out.
  - Hit: rsp_data = cache_data_out, hit_cnt++, go to RESP.
  - Miss: miss_cnt++, go to MEM_REQ (mem_req_we = 0).
- State WR_CACHE:
  - cache_we = 1 and cache_data_in = wdata for one cycle.
  - Then go to MEM_REQ with mem_req_we = 1 and mem_req_wdata = wdata.
- State MEM_REQ:
  - mem_req_valid = 1, held with stable address/data until mem_req_ready.
  - On accept: a write goes to RESP; a read goes to MEM_WAIT.
- State MEM_WAIT: on mem_rsp_valid, capture mem_rsp_data and go to FILL.
- State FILL:
  - cache_we = 1 and cache_data_in = captured data for one cycle.
  - Go to RESP; rsp_data = captured data.
- State RESP: cpu_rsp_valid = 1 for exactly one cycle, then go to IDLE. cpu_req_ready = 0.
- Timeout:
  - The cycle counter clears on entry to MEM_REQ and counts through MEM_REQ and MEM_WAIT.
  - At count TIMEOUT_CYCLES-1 without completion: mem_req_valid drops, cpu_rsp_err = 1, rsp_data = 0, go to RESP, no fill.
  - A completion in the same cycle as the limit wins over the timeout.
- mem_rsp_valid outside MEM_WAIT is ignored; this includes late responses after a timeout.
- Counters saturate at all-ones. Writes do not count as hits or misses.
- Latency from the accepting edge to cpu_rsp_valid:
  - Read hit: 3 cycles.
  - Read miss with zero-wait memory (ready immediately, rsp the next cycle): 6 cycles.
  - Write with ready immediately: 3 cycles.
- cache_re and cache_we are never asserted together.
- busy = (state != IDLE).

Decomposition:
- Package cache_ctrl_pkg holds:
  - the FSM state enum (IDLE, LOOKUP, CHECK, WR_CACHE, MEM_REQ, MEM_WAIT, FILL, RESP);
  - the default width constants ADDR_W, DATA_W and CNT_W.
- One sub-module, sat_counter (parameter WIDTH; ports clk, reset, clr, inc, count). It is instantiated twice, for hit_cnt and miss_cnt.
- The timeout counter stays inline.

Test Plan:
- Read miss then hit:
  - Read 0x0000_1040 against a cold cache; memory is ready at once and returns 0xDEAD_BEEF one cycle later.
  - Expect cpu_rsp_valid 6 cycles after accept with data 0xDEAD_BEEF, cache_we pulsed in FILL, miss_cnt = 1.
  - Re-read the same address: expect data 0xDEAD_BEEF after 3 cycles and hit_cnt = 1.
- Write-through:
  - Write 0x1234_5678 to 0x0000_2000.
  - Expect a one-cycle cache_we with that data, then mem_req_valid with mem_req_we = 1, the same addr and data.
  - Expect cpu_rsp_valid with err = 0 and data 0; counters unchanged.
- Backpressure:
  - Hold mem_req_ready = 0 for 10 cycles on a read miss.
  - Expect mem_req_valid, addr and we stable throughout; cpu_req_ready = 0; busy = 1.
- Timeout with TIMEOUT_CYCLES = 8:
  - Memory never responds.
  - Expect cpu_rsp_valid with err = 1 and data 0, no FILL cache_we, mem_req_valid low afterwards.
  - A later mem_rsp_valid is ignored.
- Reset mid-MEM_WAIT:
  - Assert reset asynchronously.
  - Expect immediate IDLE, cpu_req_ready = 1, counters 0, no cpu_rsp_valid.
- Counter saturation with CNT_W = 2: 5 read hits give hit_cnt = 3.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types and default widths for the cache request controller.
package cache_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCheck,
    StWrCache,
    StMemReq,
    StMemWait,
    StFill,
    StResp
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, holding at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_req_ctrl.sv
// Sequences CPU requests through the cache and a backing memory (write-through,
// read-allocate), with a memory timeout and hit/miss statistics.
module cache_req_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = cache_ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W         = cache_ctrl_pkg::DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = cache_ctrl_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_data,
  output logic              cpu_rsp_err,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_data_in,
  output logic              cache_we,
  output logic              cache_re,
  input  logic [DATA_W-1:0] cache_data_out,
  input  logic              cache_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              busy,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  // Wide enough to hold TIMEOUT_CYCLES: a read accepted right at the limit
  // takes one more step in MEM_WAIT before the expiry check catches it.
  localparam int unsigned     TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              accept;
  logic              tmo_expired;
  logic              hit_inc, miss_inc;

  assign accept      = cpu_req_valid && cpu_req_ready;
  assign tmo_expired = (tmo_q >= TMO_LIMIT);

  // State, timeout counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
      mem_data_q <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
      mem_data_q <= mem_data_d;
      tmo_q      <= tmo_d;
    end
  end

  // Request capture on the CPU handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= cpu_req_addr;
      we_q    <= cpu_req_we;
      wdata_q <= cpu_req_wdata;
    end
  end

  // Next-state logic and strobe outputs.
  always_comb begin
    state_d       = state_q;
    rsp_data_d    = rsp_data_q;
    err_d         = err_q;
    mem_data_d    = mem_data_q;
    tmo_d         = tmo_q;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    cpu_req_ready = 1'b0;
    cache_re      = 1'b0;
    cache_we      = 1'b0;
    cache_data_in = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_wdata = '0;

    unique case (state_q)
      StIdle: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          rsp_data_d = '0;
          err_d      = 1'b0;
          state_d    = cpu_req_we ? StWrCache : StLookup;
        end
      end
      StLookup: begin
        cache_re = 1'b1;
        state_d  = StCheck;
      end
      StCheck: begin
        if (cache_hit) begin
          rsp_data_d = cache_data_out;
          hit_inc    = 1'b1;
          state_d    = StResp;
        end else begin
          miss_inc = 1'b1;
          tmo_d    = '0;
          state_d  = StMemReq;
        end
      end
      StWrCache: begin
        cache_we      = 1'b1;
        cache_data_in = wdata_q;
        tmo_d         = '0;
        state_d       = StMemReq;
      end
      StMemReq: begin
        mem_req_valid = 1'b1;
        mem_req_we    = we_q;
        mem_req_wdata = we_q ? wdata_q : '0;
        tmo_d         = tmo_q + 1'b1;
        // Acceptance takes priority over an expiry in the same cycle.
        if (mem_req_ready) begin
          state_d = we_q ? StResp : StMemWait;
        end else if (tmo_expired) begin
          err_d      = 1'b1;
          rsp_data_d = '0;
          state_d    = StResp;
        end
      end
      StMemWait: begin
        tmo_d = tmo_q + 1'b1;
        if (mem_rsp_valid) begin
          mem_data_d = mem_rsp_data;
          state_d    = StFill;
        end else if (tmo_expired) begin
          err_d      = 1'b1;
          rsp_data_d = '0;
          state_d    = StResp;
        end
      end
      StFill: begin
        cache_we      = 1'b1;
        cache_data_in = mem_data_q;
        rsp_data_d    = mem_data_q;
        state_d       = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Response and status outputs; address buses are zero while idle.
  always_comb begin
    busy          = (state_q != StIdle);
    cpu_rsp_valid = (state_q == StResp);
    cpu_rsp_data  = (state_q == StResp) ? rsp_data_q : '0;
    cpu_rsp_err   = (state_q == StResp) && err_q;
    cache_addr    = (state_q != StIdle) ? addr_q : '0;
    mem_req_addr  = (state_q != StIdle) ? addr_q : '0;
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (hit_inc),
    .count (hit_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (miss_inc),
    .count (miss_cnt)
  );

endmodule

// File: tb/tb_cache_req_ctrl.sv
// Directed bench: a main instance (CNT_W=2) and a short-timeout instance (TIMEOUT_CYCLES=8)
// share a small cache model and a scripted memory.
module tb_cache_req_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus
  logic        m_valid = 1'b0, t_valid = 1'b0;
  logic        cpu_req_we = 1'b0;
  logic [31:0] cpu_req_addr = '0, cpu_req_wdata = '0;
  logic        c_hit = 1'b0;
  logic [31:0] c_data = '0;
  logic        mem_req_ready = 1'b1;
  logic        rsp_en = 1'b1, rsp_force = 1'b0, rsp_pend = 1'b0;
  logic [31:0] mem_word = '0;
  logic        mem_rsp_valid;
  assign mem_rsp_valid = (rsp_pend && rsp_en) || rsp_force;

  // Main instance outputs
  logic        m_cpu_req_ready, m_cpu_rsp_valid, m_cpu_rsp_err, m_cache_we, m_cache_re;
  logic        m_mem_req_valid, m_mem_req_we, m_busy;
  logic [31:0] m_cpu_rsp_data, m_cache_addr, m_cache_data_in, m_mem_req_addr, m_mem_req_wdata;
  logic [1:0]  m_hit_cnt, m_miss_cnt;

  // Timeout instance outputs
  logic        t_cpu_req_ready, t_cpu_rsp_valid, t_cpu_rsp_err, t_cache_we, t_cache_re;
  logic        t_mem_req_valid, t_mem_req_we, t_busy;
  logic [31:0] t_cpu_rsp_data, t_cache_addr, t_cache_data_in, t_mem_req_addr, t_mem_req_wdata;
  logic [1:0]  t_hit_cnt, t_miss_cnt;

  cache_req_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(256), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(m_valid), .cpu_req_ready(m_cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(m_cpu_rsp_valid), .cpu_rsp_data(m_cpu_rsp_data), .cpu_rsp_err(m_cpu_rsp_err),
    .cache_addr(m_cache_addr), .cache_data_in(m_cache_data_in), .cache_we(m_cache_we),
    .cache_re(m_cache_re), .cache_data_out(c_data), .cache_hit(c_hit),
    .mem_req_valid(m_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(m_mem_req_we),
    .mem_req_addr(m_mem_req_addr), .mem_req_wdata(m_mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_word),
    .busy(m_busy), .hit_cnt(m_hit_cnt), .miss_cnt(m_miss_cnt)
  );

  cache_req_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8), .CNT_W(2)) dut_t (
    .clk(clk), .reset(reset),
    .cpu_req_valid(t_valid), .cpu_req_ready(t_cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(t_cpu_rsp_valid), .cpu_rsp_data(t_cpu_rsp_data), .cpu_rsp_err(t_cpu_rsp_err),
    .cache_addr(t_cache_addr), .cache_data_in(t_cache_data_in), .cache_we(t_cache_we),
    .cache_re(t_cache_re), .cache_data_out(c_data), .cache_hit(c_hit),
    .mem_req_valid(t_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(t_mem_req_we),
    .mem_req_addr(t_mem_req_addr), .mem_req_wdata(t_mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_word),
    .busy(t_busy), .hit_cnt(t_hit_cnt), .miss_cnt(t_miss_cnt)
  );

  // Cache model: 8 direct-mapped slots indexed by addr[14:12], full-address tag,
  // registered lookup result.
  logic [7:0]  c_vld = '0;
  logic [31:0] c_tag [8];
  logic [31:0] c_dat [8];

  always @(posedge clk) begin
    if (m_cache_re) begin
      c_hit  <= c_vld[m_cache_addr[14:12]] && (c_tag[m_cache_addr[14:12]] == m_cache_addr);
      c_data <= c_dat[m_cache_addr[14:12]];
    end else if (t_cache_re) begin
      c_hit  <= c_vld[t_cache_addr[14:12]] && (c_tag[t_cache_addr[14:12]] == t_cache_addr);
      c_data <= c_dat[t_cache_addr[14:12]];
    end else begin
      c_hit  <= 1'b0;
      c_data <= '0;
    end
    if (m_cache_we) begin
      c_vld[m_cache_addr[14:12]] <= 1'b1;
      c_tag[m_cache_addr[14:12]] <= m_cache_addr;
      c_dat[m_cache_addr[14:12]] <= m_cache_data_in;
    end else if (t_cache_we) begin
      c_vld[t_cache_addr[14:12]] <= 1'b1;
      c_tag[t_cache_addr[14:12]] <= t_cache_addr;
      c_dat[t_cache_addr[14:12]] <= t_cache_data_in;
    end
  end

  // Memory model: read data one cycle after an accepted read request.
  always @(posedge clk) rsp_pend <= m_mem_req_valid && mem_req_ready && !m_mem_req_we;

  // Bus monitor
  int          cwe_n = 0, mreq_n = 0, both_n = 0, tcwe_n = 0;
  logic [31:0] cwe_addr = '0, cwe_data = '0, mreq_addr = '0, mreq_wdata = '0;
  logic        mreq_we = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      if (m_cache_we) begin
        cwe_n    <= cwe_n + 1;
        cwe_addr <= m_cache_addr;
        cwe_data <= m_cache_data_in;
      end
      if (m_mem_req_valid && mem_req_ready) begin
        mreq_n     <= mreq_n + 1;
        mreq_we    <= m_mem_req_we;
        mreq_addr  <= m_mem_req_addr;
        mreq_wdata <= m_mem_req_wdata;
      end
      if ((m_cache_we && m_cache_re) || (t_cache_we && t_cache_re)) both_n <= both_n + 1;
      if (t_cache_we) tcwe_n <= tcwe_n + 1;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on the main instance; lat counts negedges after the accepting edge.
  task automatic main_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] data, output logic err);
    @(negedge clk);
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    m_valid       = 1'b1;
    @(posedge clk);
    #1 m_valid = 1'b0;
    lat  = -1;
    data = 'x;
    err  = 1'bx;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (m_cpu_rsp_valid) begin
        lat  = i;
        data = m_cpu_rsp_data;
        err  = m_cpu_rsp_err;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, mem_data, exp_data, exp_lat, exp_cwe, exp_cwe_data, exp_mreq;
    logic [31:0] exp_hit, exp_miss;
  } vec_t;

  vec_t        vecs [11];
  int          lat, n0, r0;
  logic [31:0] data;
  logic        err;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           we    addr          wdata         mem           exp_data      lat cwe cwe_data     mreq hit miss
    vecs[0]  = '{1'b0, 32'h0000_1040, 32'h0,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 6, 1, 32'hDEAD_BEEF, 1, 0, 1};
    vecs[1]  = '{1'b0, 32'h0000_1040, 32'h0,        32'h0,         32'hDEAD_BEEF, 3, 0, 32'h0,         0, 1, 1};
    vecs[2]  = '{1'b1, 32'h0000_2000, 32'h1234_5678, 32'h0,        32'h0,         3, 1, 32'h1234_5678, 1, 1, 1};
    vecs[3]  = '{1'b0, 32'h0000_2000, 32'h0,        32'h0,         32'h1234_5678, 3, 0, 32'h0,         0, 2, 1};
    vecs[4]  = '{1'b0, 32'h0000_3000, 32'h0,        32'hCAFE_F00D, 32'hCAFE_F00D, 6, 1, 32'hCAFE_F00D, 1, 2, 2};
    vecs[5]  = '{1'b0, 32'h0000_3000, 32'h0,        32'h0,         32'hCAFE_F00D, 3, 0, 32'h0,         0, 3, 2};
    vecs[6]  = '{1'b0, 32'h0000_1040, 32'h0,        32'h0,         32'hDEAD_BEEF, 3, 0, 32'h0,         0, 3, 2};
    vecs[7]  = '{1'b0, 32'h0000_4000, 32'h0,        32'h0,         32'h0,         6, 1, 32'h0,         1, 3, 3};
    vecs[8]  = '{1'b0, 32'h0000_5000, 32'h0,        32'hA5A5_5A5A, 32'hA5A5_5A5A, 6, 1, 32'hA5A5_5A5A, 1, 3, 3};
    vecs[9]  = '{1'b1, 32'h0000_1040, 32'h0BAD_F00D, 32'h0,        32'h0,         3, 1, 32'h0BAD_F00D, 1, 3, 3};
    vecs[10] = '{1'b0, 32'h0000_1040, 32'h0,        32'h0,         32'h0BAD_F00D, 3, 0, 32'h0,         0, 3, 3};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctrl", {26'd0, m_cpu_req_ready, m_cpu_rsp_valid, m_cpu_rsp_err, m_cache_we,
                       m_cache_re, m_mem_req_valid}, 32'h20);
    check("rst_busy", {31'd0, m_busy}, 32'h0);
    check("rst_cnts", {28'd0, m_hit_cnt, m_miss_cnt}, 32'h0);
    check("rst_addr", m_cache_addr | m_mem_req_addr | m_cpu_rsp_data, 32'h0);
    reset = 1'b0;

    // Table-driven transactions with zero-wait memory
    foreach (vecs[k]) begin
      mem_word = vecs[k].mem_data;
      n0 = cwe_n;
      r0 = mreq_n;
      main_txn(vecs[k].we, vecs[k].addr, vecs[k].wdata, lat, data, err);
      check($sformatf("v%0d_lat", k), 32'(lat), vecs[k].exp_lat);
      check($sformatf("v%0d_data", k), data, vecs[k].exp_data);
      check($sformatf("v%0d_err", k), {31'd0, err}, 32'h0);
      check($sformatf("v%0d_hit", k), {30'd0, m_hit_cnt}, vecs[k].exp_hit);
      check($sformatf("v%0d_miss", k), {30'd0, m_miss_cnt}, vecs[k].exp_miss);
      check($sformatf("v%0d_cwe_n", k), 32'(cwe_n - n0), vecs[k].exp_cwe);
      check($sformatf("v%0d_mreq_n", k), 32'(mreq_n - r0), vecs[k].exp_mreq);
      if (cwe_n != n0) begin
        check($sformatf("v%0d_cwe_addr", k), cwe_addr, vecs[k].addr);
        check($sformatf("v%0d_cwe_data", k), cwe_data, vecs[k].exp_cwe_data);
      end
      if (mreq_n != r0) begin
        check($sformatf("v%0d_mreq_we", k), {31'd0, mreq_we}, {31'd0, vecs[k].we});
        check($sformatf("v%0d_mreq_addr", k), mreq_addr, vecs[k].addr);
        if (vecs[k].we) check($sformatf("v%0d_mreq_wdata", k), mreq_wdata, vecs[k].wdata);
      end
    end

    // Backpressure: memory holds off for 10 cycles on a read miss
    mem_req_ready = 1'b0;
    mem_word      = 32'h600D_600D;
    @(negedge clk);
    cpu_req_we   = 1'b0;
    cpu_req_addr = 32'h0000_6000;
    m_valid      = 1'b1;
    @(posedge clk);
    #1 m_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_ctrl%0d", i), {28'd0, m_mem_req_valid, m_mem_req_we, m_cpu_req_ready,
                                         m_busy}, 32'h9);
      check($sformatf("bp_addr%0d", i), m_mem_req_addr, 32'h0000_6000);
    end
    mem_req_ready = 1'b1;
    data = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_cpu_rsp_valid) begin
        data = m_cpu_rsp_data;
        break;
      end
    end
    check("bp_data", data, 32'h600D_600D);

    // Timeout on the short-timeout instance: accepted, never answered
    rsp_en = 1'b0;
    n0     = tcwe_n;
    @(negedge clk);
    cpu_req_we   = 1'b0;
    cpu_req_addr = 32'h0000_7000;
    t_valid      = 1'b1;
    @(posedge clk);
    #1 t_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 3) begin
        check("t_mreq", {30'd0, t_mem_req_valid, t_mem_req_we}, 32'h2);
        check("t_mreq_addr", t_mem_req_addr, 32'h0000_7000);
        check("t_mreq_wdata", t_mem_req_wdata, 32'h0);
      end
      if (t_cpu_rsp_valid) begin
        lat  = i;
        data = t_cpu_rsp_data;
        err  = t_cpu_rsp_err;
        break;
      end
    end
    check("to_lat", 32'(lat), 32'd11);
    check("to_err", {31'd0, err}, 32'h1);
    check("to_data", data, 32'h0);
    check("to_miss", {28'd0, t_hit_cnt, t_miss_cnt}, 32'h1);
    @(negedge clk);
    check("to_after", {29'd0, t_mem_req_valid, t_busy, t_cpu_req_ready}, 32'h1);
    rsp_force = 1'b1;
    @(negedge clk);
    rsp_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("late_rsp%0d", i), {29'd0, t_cpu_rsp_valid, t_cache_we, t_busy}, 32'h0);
    end
    check("to_no_fill", 32'(tcwe_n - n0), 32'h0);

    // Reset while the main instance waits in MEM_WAIT
    @(negedge clk);
    cpu_req_addr = 32'h0000_6100;
    m_valid      = 1'b1;
    @(posedge clk);
    #1 m_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mw_busy", {31'd0, m_busy}, 32'h1);
    #3 reset = 1'b1;
    #1;
    check("ar_ctrl", {28'd0, m_cpu_req_ready, m_busy, m_cpu_rsp_valid, m_cache_we}, 32'h8);
    check("ar_cnts", {28'd0, m_hit_cnt, m_miss_cnt}, 32'h0);
    check("ar_addr", m_cache_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rsp_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("ar_quiet%0d", i), {29'd0, m_cpu_rsp_valid, m_cache_we, m_busy}, 32'h0);
    end

    // Saturation: five hits on a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      main_txn(1'b0, 32'h0000_1040, 32'h0, lat, data, err);
      check($sformatf("sat_lat%0d", i), 32'(lat), 32'd3);
      check($sformatf("sat_data%0d", i), data, 32'h0BAD_F00D);
      check($sformatf("sat_hit%0d", i), {30'd0, m_hit_cnt}, (i < 3) ? 32'(i + 1) : 32'd3);
    end
    check("sat_miss", {30'd0, m_miss_cnt}, 32'h0);
    check("re_we_excl", 32'(both_n), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
